// File: rtl/fetch_prefetch_queue.sv
// Instruction fetch front end: sequential fetch, in-order response queue, redirect flush.
// Optional macro PREFETCH_BYPASS_EN forwards a response to IF/ID in the same cycle when the queue is empty.
module fetch_prefetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        redirect,
   input  logic [63:0] redirect_pc,
   output logic        imem_req,
   output logic [63:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        out_valid,
   output logic [31:0] out_instr,
   output logic [63:0] out_pc,
   input  logic        out_ready
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};
   localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);

   logic [63:0]   fetch_pc_r;
   logic [63:0]   resp_pc_r;
   logic [63:0]   pc_mem_r    [DEPTH];
   logic [31:0]   instr_mem_r [DEPTH];
   logic [AW-1:0] rd_ptr_r;
   logic [AW-1:0] wr_ptr_r;
   logic [CW-1:0] count_r;
   logic [CW-1:0] inflight_r;
   logic [CW-1:0] drop_cnt_r;

   logic [CW:0]   credit_s;
   logic          accept_s;
   logic          resp_ok_s;
   logic          keep_s;
   logic          byp_s;
   logic          push_s;
   logic          pop_s;

   // Issue credit covers both queued words and outstanding requests, so a kept response always has a slot.
   assign credit_s  = {1'b0, inflight_r} + {1'b0, count_r};
   assign imem_req  = !reset && !redirect && (credit_s < DEPTH_C);
   assign imem_addr = fetch_pc_r;
   assign accept_s  = imem_req && imem_ready;
   assign resp_ok_s = !reset && imem_rvalid && (inflight_r != ZERO_C);
   assign keep_s    = resp_ok_s && (drop_cnt_r == ZERO_C);
   assign pop_s     = !reset && !redirect && out_ready && (count_r != ZERO_C);
   assign push_s    = keep_s && !redirect && !(byp_s && out_ready);

   // Output selection: queue head, or the live response when bypass is enabled and the queue is empty.
   always_comb begin
      byp_s     = 1'b0;
      out_valid = !reset && !redirect && (count_r != ZERO_C);
      out_instr = instr_mem_r[rd_ptr_r];
      out_pc    = pc_mem_r[rd_ptr_r];
`ifdef PREFETCH_BYPASS_EN
      if (keep_s && !redirect && (count_r == ZERO_C)) begin
         byp_s     = 1'b1;
         out_valid = 1'b1;
         out_instr = imem_rdata;
         out_pc    = resp_pc_r;
      end else begin
         byp_s     = 1'b0;
      end
`endif
   end

   // Queue storage; contents are only meaningful under count_r, so no reset is needed.
   always_ff @(posedge clk) begin
      if (push_s) begin
         pc_mem_r[wr_ptr_r]    <= resp_pc_r;
         instr_mem_r[wr_ptr_r] <= imem_rdata;
      end
   end

   // Control state: reset, then redirect, then normal issue/response/pop bookkeeping.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_r <= RESET_PC;
         resp_pc_r  <= RESET_PC;
         rd_ptr_r   <= {AW{1'b0}};
         wr_ptr_r   <= {AW{1'b0}};
         count_r    <= ZERO_C;
         inflight_r <= ZERO_C;
         drop_cnt_r <= ZERO_C;
      end else if (redirect) begin
         fetch_pc_r <= redirect_pc;
         resp_pc_r  <= redirect_pc;
         rd_ptr_r   <= {AW{1'b0}};
         wr_ptr_r   <= {AW{1'b0}};
         count_r    <= ZERO_C;
         // Everything still outstanding after this cycle's response belongs to the abandoned stream.
         inflight_r <= inflight_r - CW'(resp_ok_s);
         drop_cnt_r <= inflight_r - CW'(resp_ok_s);
      end else begin
         if (accept_s) begin
            fetch_pc_r <= fetch_pc_r + 64'd4;
         end
         if (keep_s) begin
            resp_pc_r <= resp_pc_r + 64'd4;
         end
         if (resp_ok_s && (drop_cnt_r != ZERO_C)) begin
            drop_cnt_r <= drop_cnt_r - CW'(1'b1);
         end
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1'b1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1'b1);
         end
         inflight_r <= inflight_r + CW'(accept_s) - CW'(resp_ok_s);
         count_r    <= count_r + CW'(push_s) - CW'(pop_s);
      end
   end

endmodule
